// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: operation encoding and controller states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Cell operation code: AND/OR pass through, ADD/SUB both use the adder path.
    function automatic logic [1:0] cell_op(input alu_op_e op);
        logic [1:0] code;
        case (op)
            OP_AND:  code = 2'b00;
            OP_OR:   code = 2'b01;
            OP_ADD:  code = 2'b10;
            OP_SUB:  code = 2'b10;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/one_bit_ALU.sv
// One-bit ALU cell: AND, OR or full-add of a single bit slice.
module one_bit_ALU (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);

    // Bit-slice function select; carry is the full-adder majority term.
    always_comb begin
        result    = 1'b0;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
        case (operation)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b ^ carry_in;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// WIDTH-bit ALU processing one bit per clock through a single one_bit_ALU cell,
// with a start/busy/done handshake and registered result and flags.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_r;
    state_e           state_next_s;
    alu_op_e          op_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_next_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             carry_out_r;
    logic             zero_r;
    logic             overflow_r;
    logic             accept_s;
    logic             last_s;
    logic             arith_s;
    logic             cell_b_s;
    logic             cell_result_s;
    logic             cell_carry_s;

    assign accept_s      = start && (state_r != BUSY);
    assign last_s        = (state_r == BUSY) && (cnt_r == LAST_BIT);
    assign arith_s       = (op_r == OP_ADD) || (op_r == OP_SUB);
    assign cell_b_s      = b_sh_r[0] ^ (op_r == OP_SUB);
    assign result_next_s = {cell_result_s, result_r[WIDTH-1:1]};

    one_bit_ALU u_cell (
        .a         (a_sh_r[0]),
        .b         (cell_b_s),
        .carry_in  (carry_r),
        .operation (cell_op(op_r)),
        .result    (cell_result_s),
        .carry_out (cell_carry_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = BUSY;
                else          state_next_s = IDLE;
            end
            BUSY: begin
                if (last_s) state_next_s = DONE;
                else        state_next_s = BUSY;
            end
            DONE: begin
                if (accept_s) state_next_s = BUSY;
                else          state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, serial shifting and flag latching on the final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r        <= OP_AND;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            result_r    <= '0;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (accept_s) begin
            op_r        <= alu_op_e'(op);
            a_sh_r      <= a;
            b_sh_r      <= b;
            cnt_r       <= '0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            case (alu_op_e'(op))
                OP_ADD:  carry_r <= carry_in;
                OP_SUB:  carry_r <= 1'b1;
                default: carry_r <= 1'b0;
            endcase
        end else if (state_r == BUSY) begin
            a_sh_r   <= a_sh_r >> 1;
            b_sh_r   <= b_sh_r >> 1;
            result_r <= result_next_s;
            carry_r  <= cell_carry_s;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                // carry_r here is the carry into the MSB.
                carry_out_r <= arith_s & cell_carry_s;
                overflow_r  <= arith_s & (carry_r ^ cell_carry_s);
                zero_r      <= ~|result_next_s;
            end else begin
                carry_out_r <= carry_out_r;
                overflow_r  <= overflow_r;
                zero_r      <= zero_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy      = (state_r == BUSY);
    assign done      = (state_r == DONE);
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;

endmodule
